instr_fetch: RTL and testbench

Multi-cycle instruction fetch unit that supplies the main controller with `OpCode`, `funct`, and `nop`. It also supplies the datapath with the remaining instruction fields and `pc_plus4`. It owns the PC and runs a request/acknowledge handshake to instruction memory. It consumes the controller's `jump`/`Branch` decisions, plus the ALU `zero` flag, to select the next PC. It holds `nop` high whenever no valid instruction is being issued.

---
 rtl/fetch_pkg.sv | 36 +++
 rtl/instr_fetch_npc_calc.sv | 33 +++
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/controller encodings, state enum and instruction layout.
// Imported by instr_fetch and npc_calc; no logic of its own.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    ISSUE = 2'b10
  } fetch_state_e;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_JAL  = 2'b10;
  localparam logic [1:0] JUMP_JR   = 2'b11;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // R-type view of the instruction word; I/J fields are slices of the same bits
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_t;

  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_npc_calc.sv
// Next-PC selection: jr > j/jal > taken branch > fall-through.
// Purely combinational, zero latency, no flow control.
module npc_calc
  import fetch_pkg::*;
(
  input  logic [1:0]  jump,
  input  logic [1:0]  branch,
  input  logic        zero,
  input  logic [31:0] jr_target,
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  logic [15:0] imm16,
  output logic [31:0] npc
);

  logic br_taken;

  // Branch code 11 matches neither compare and therefore falls through
  assign br_taken = ((branch == BR_BEQ) &&  zero) ||
                    ((branch == BR_BNE) && !zero);

  always_comb begin
    npc = pc_plus4;
    if (jump == JUMP_JR) begin
      npc = jr_target;
    end else if ((jump == JUMP_J) || (jump == JUMP_JAL)) begin
      npc = {pc_plus4[31:28], instr_index, 2'b00};
    end else if (br_taken) begin
      npc = pc_plus4 + br_offset(imm16);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle fetch unit: owns the PC, handshakes imem, issues one word per ack.
// Latency: ack in FETCH -> ISSUE next cycle -> next FETCH after; stall holds ISSUE.
// Optional INSTR_FETCH_DELAY_SLOT_EN: redirects take effect after one delay slot.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  jump,
  input  logic [1:0]  Branch,
  input  logic        zero,
  input  logic [31:0] jr_target,
  output logic [5:0]  OpCode,
  output logic [5:0]  funct,
  output logic [4:0]  shamt,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [25:0] instr_index,
  output logic [31:0] pc_plus4,
  output logic        nop
);

  fetch_state_e state_q, state_d;
  instr_t       ir_q;
  logic [31:0]  pc_q;
  logic [31:0]  pc_plus4_q;
  logic [31:0]  npc;
  logic [31:0]  pc_load;
  logic         ack_take;
  logic         issue_go;

  assign ack_take = (state_q == FETCH) && imem_ack;
  assign issue_go = (state_q == ISSUE) && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   if (imem_ack) state_d = ISSUE;
      ISSUE:   if (!stall)   state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  npc_calc u_npc_calc (
    .jump        (jump),
    .branch      (Branch),
    .zero        (zero),
    .jr_target   (jr_target),
    .pc_plus4    (pc_plus4_q),
    .instr_index (ir_q[25:0]),
    .imm16       (ir_q[15:0]),
    .npc         (npc)
  );

`ifdef INSTR_FETCH_DELAY_SLOT_EN
  logic        pend_vld_q;
  logic [31:0] pend_pc_q;
  logic        redirect;

  assign redirect = (npc != pc_plus4_q);

  // The slot's own redirect is dropped while a target is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
    end else if (issue_go) begin
      if (pend_vld_q) begin
        pend_vld_q <= 1'b0;
      end else if (redirect) begin
        pend_vld_q <= 1'b1;
        pend_pc_q  <= npc;
      end
    end
  end

  assign pc_load = pend_vld_q ? pend_pc_q : pc_plus4_q;
`else
  assign pc_load = npc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      pc_plus4_q <= '0;
    end else if (ack_take) begin
      ir_q       <= imem_rdata;
      pc_plus4_q <= pc_q + 32'd4;
    end else if (issue_go) begin
      pc_q <= pc_load;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign nop         = !issue_go;
  assign pc_plus4    = pc_plus4_q;
  assign OpCode      = ir_q.opcode;
  assign funct       = ir_q.funct;
  assign shamt       = ir_q.shamt;
  assign rs          = ir_q.rs;
  assign rt          = ir_q.rt;
  assign rd          = ir_q.rd;
  assign imm16       = ir_q[15:0];
  assign instr_index = ir_q[25:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with hand-computed next-PC values.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  jump;
  logic [1:0]  Branch;
  logic        zero;
  logic [31:0] jr_target;
  logic [5:0]  OpCode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] pc_plus4;
  logic        nop;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .jump        (jump),
    .Branch      (Branch),
    .zero        (zero),
    .jr_target   (jr_target),
    .OpCode      (OpCode),
    .funct       (funct),
    .shamt       (shamt),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm16       (imm16),
    .instr_index (instr_index),
    .pc_plus4    (pc_plus4),
    .nop         (nop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called in a FETCH cycle at the falling edge; returns in the following FETCH
  task automatic issue_word(input string tag, input logic [31:0] exp_pc, input logic [31:0] word,
                            input int ack_dly, input int stall_n,
                            input logic [1:0] j, input logic [1:0] br, input logic z,
                            input logic [31:0] jr, input logic [31:0] exp_next);
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 1'b0;
      #1;
      chk({tag, ".wait_req"},  32'(imem_req), 32'd1);
      chk({tag, ".wait_addr"}, imem_addr, exp_pc);
      chk({tag, ".wait_nop"},  32'(nop), 32'd1);
      step();
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    #1;
    chk({tag, ".req"},  32'(imem_req), 32'd1);
    chk({tag, ".addr"}, imem_addr, exp_pc);
    chk({tag, ".fetch_nop"}, 32'(nop), 32'd1);
    step();
    imem_ack   = 1'b0;
    imem_rdata = ~word;
    for (int i = 0; i < stall_n; i++) begin
      stall     = 1'b1;
      jump      = 2'b11;
      Branch    = 2'b01;
      zero      = 1'b1;
      jr_target = 32'hDEAD_BEE0;
      #1;
      chk({tag, ".stall_nop"}, 32'(nop), 32'd1);
      chk({tag, ".stall_op"},  32'(OpCode), 32'(word[31:26]));
      chk({tag, ".stall_idx"}, 32'(instr_index), 32'(word[25:0]));
      chk({tag, ".stall_req"}, 32'(imem_req), 32'd0);
      step();
    end
    stall     = 1'b0;
    jump      = j;
    Branch    = br;
    zero      = z;
    jr_target = jr;
    #1;
    chk({tag, ".issue_nop"}, 32'(nop), 32'd0);
    chk({tag, ".pc_plus4"},  pc_plus4, exp_pc + 32'd4);
    chk({tag, ".opcode"},    32'(OpCode), 32'(word[31:26]));
    chk({tag, ".rs_rt"},     32'({rs, rt}), 32'(word[25:16]));
    chk({tag, ".rd_sh_fn"},  32'({rd, shamt, funct}), 32'(word[15:0]));
    chk({tag, ".imm16"},     32'(imm16), 32'(word[15:0]));
    step();
    jump   = 2'b00;
    Branch = 2'b00;
    zero   = 1'b0;
    #1;
    chk({tag, ".next_addr"}, imem_addr, exp_next);
    chk({tag, ".next_req"},  32'(imem_req), 32'd1);
    chk({tag, ".next_nop"},  32'(nop), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    stall      = 1'b0;
    jump       = 2'b00;
    Branch     = 2'b00;
    zero       = 1'b0;
    jr_target  = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst.req",      32'(imem_req), 32'd0);
    chk("rst.nop",      32'(nop), 32'd1);
    chk("rst.addr",     imem_addr, 32'h0000_3000);
    chk("rst.pc_plus4", pc_plus4, 32'h0);
    chk("rst.opcode",   32'(OpCode), 32'd0);
    chk("rst.index",    32'(instr_index), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle.req", 32'(imem_req), 32'd0);
    step();

`ifdef INSTR_FETCH_DELAY_SLOT_EN
    issue_word("ds_jump", 32'h0000_3000, 32'h0800_0C40, 0, 0, 2'b01, 2'b00, 1'b0, 32'h0, 32'h0000_3004);
    issue_word("ds_slot", 32'h0000_3004, 32'h0085_1020, 0, 2, 2'b11, 2'b00, 1'b0, 32'h0000_5000, 32'h0000_3100);
    issue_word("ds_tgt",  32'h0000_3100, 32'h0085_1020, 0, 0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0000_3104);
`else
    issue_word("beq_t",   32'h0000_3000, 32'h1109_0003, 0, 0, 2'b00, 2'b01, 1'b1, 32'h0, 32'h0000_3010);
    issue_word("beq_nt",  32'h0000_3010, 32'h1109_0003, 0, 0, 2'b00, 2'b01, 1'b0, 32'h0, 32'h0000_3014);
    issue_word("bne_neg", 32'h0000_3014, 32'h1509_FFFE, 0, 0, 2'b00, 2'b10, 1'b0, 32'h0, 32'h0000_3010);
    issue_word("j",       32'h0000_3010, 32'h0800_0C10, 0, 0, 2'b01, 2'b00, 1'b0, 32'h0, 32'h0000_3040);
    issue_word("jr_prio", 32'h0000_3040, 32'h03E0_0008, 0, 0, 2'b11, 2'b01, 1'b1, 32'h0000_3024, 32'h0000_3024);
    issue_word("ackdly",  32'h0000_3024, 32'h0085_1020, 3, 4, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0000_3028);
    issue_word("br11",    32'h0000_3028, 32'h1109_0003, 0, 0, 2'b00, 2'b11, 1'b1, 32'h0, 32'h0000_302C);
    issue_word("jr_hi",   32'h0000_302C, 32'h03E0_0008, 0, 0, 2'b11, 2'b00, 1'b0, 32'hF000_0000, 32'hF000_0000);
    issue_word("jal_hi",  32'hF000_0000, 32'h0C00_0010, 0, 0, 2'b10, 2'b00, 1'b0, 32'h0, 32'hF000_0040);
    issue_word("jr_top",  32'hF000_0040, 32'h03E0_0008, 0, 0, 2'b11, 2'b00, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    issue_word("wrap",    32'hFFFF_FFFC, 32'h0085_1020, 0, 0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0000_0000);
`endif

    // Reset while a fetch is outstanding, then a stale ack after release
    imem_ack = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("arst.req",      32'(imem_req), 32'd0);
    chk("arst.nop",      32'(nop), 32'd1);
    chk("arst.addr",     imem_addr, 32'h0000_3000);
    chk("arst.pc_plus4", pc_plus4, 32'h0);
    step();
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0800_0C40;
    #1;
    chk("late.idle_req", 32'(imem_req), 32'd0);
    step();
    imem_ack = 1'b0;
    #1;
    chk("late.req",    32'(imem_req), 32'd1);
    chk("late.addr",   imem_addr, 32'h0000_3000);
    chk("late.opcode", 32'(OpCode), 32'd0);
    chk("late.nop",    32'(nop), 32'd1);
    issue_word("restart", 32'h0000_3000, 32'h0085_1020, 0, 0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0000_3004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
